// File: rtl/r3_stride_gather_pkg.sv
// Shared types for the radix-3 stride gather: complex sample, FSM states, stride helper.
package r3_pkg;

    localparam int R3_DW = 32;

    typedef struct packed {
        logic [R3_DW-1:0] re;
        logic [R3_DW-1:0] im;
    } cplx_t;

    localparam cplx_t CPLX_ZERO = {(2 * R3_DW){1'b0}};

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } r3_state_e;

    function automatic int stride(input int n);
        return n / 3;
    endfunction

endpackage

// File: rtl/r3_stride_gather_bank.sv
// N-entry complex sample store: one synchronous write port, three combinational read ports.
module r3_bank
    import r3_pkg::*;
#(
    parameter int N  = 9,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cplx_t         wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output cplx_t         rdata0,
    output cplx_t         rdata1,
    output cplx_t         rdata2
);

    cplx_t mem_r [N];

    // Sample write; contents need no reset since reads are gated by fill state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/r3_stride_gather.sv
// Buffers an N-point complex frame and emits N/3 stride triples for a radix-3 DIF stage.
// Optional R3_PINGPONG_EN: two banks so filling and draining overlap.
module r3_stride_gather
    import r3_pkg::*;
#(
    parameter int N  = 9,
    parameter int DW = R3_DW,
    parameter int AW = $clog2(N),
    parameter int TW = ($clog2(N / 3) < 1) ? 1 : $clog2(N / 3)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] x0_re,
    output logic [DW-1:0] x0_im,
    output logic [DW-1:0] x1_re,
    output logic [DW-1:0] x1_im,
    output logic [DW-1:0] x2_re,
    output logic [DW-1:0] x2_im,
    output logic [TW-1:0] out_idx,
    output logic          out_last
);

`ifdef R3_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    localparam int            S       = stride(N);
    localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
    localparam logic [AW-1:0] OFS1    = AW'(S);
    localparam logic [AW-1:0] OFS2    = AW'(2 * S);
    localparam logic [TW-1:0] ZERO_T  = {TW{1'b0}};
    localparam logic [TW-1:0] ONE_T   = TW'(1);
    localparam logic [TW-1:0] RD_LAST = TW'(S - 1);

    r3_state_e     state_r, state_nx_s;
    logic [AW-1:0] wr_cnt_r, wr_cnt_nx_s;
    logic [TW-1:0] rd_cnt_r, rd_cnt_nx_s;
    logic [NB-1:0] full_r, full_nx_s;
    logic          in_ready_r, in_ready_nx_s;
    logic          out_last_r, out_last_nx_s;
    cplx_t         x0_r, x1_r, x2_r;

    logic          accept_s, xfer_s, wr_last_s, rd_last_s, draining_s;
    logic          cur_avail_s, next_avail_s, same_bank_s, load_s;
    logic [TW-1:0] ld_idx_s;
    logic [NB-1:0] bank_we_s;
    logic [AW-1:0] ra_s [3];
    cplx_t         bank_rd_s [NB][3];
    cplx_t         rd_sel_s [3];
    cplx_t         in_cplx_s;

    assign in_cplx_s  = {in_re, in_im};
    assign draining_s = (state_r == DRAIN);
    assign accept_s   = in_valid & in_ready_r;
    assign xfer_s     = draining_s & out_ready;
    assign wr_last_s  = accept_s & (wr_cnt_r == WR_LAST);
    assign rd_last_s  = xfer_s & out_last_r;

    // Write pointer: wraps at the end of each frame.
    always_comb begin
        if (wr_last_s) begin
            wr_cnt_nx_s = ZERO_A;
        end else if (accept_s) begin
            wr_cnt_nx_s = wr_cnt_r + ONE_A;
        end else begin
            wr_cnt_nx_s = wr_cnt_r;
        end
    end

`ifdef R3_PINGPONG_EN
    logic wr_bank_r, wr_bank_nx_s;
    logic rd_bank_r, rd_bank_nx_s;

    // Bank occupancy and pointers: a bank becomes full on its Nth write, free after its last triple.
    always_comb begin
        full_nx_s    = full_r;
        wr_bank_nx_s = wr_bank_r;
        rd_bank_nx_s = rd_bank_r;
        if (wr_last_s) begin
            full_nx_s[wr_bank_r] = 1'b1;
            wr_bank_nx_s         = ~wr_bank_r;
        end else begin
            wr_bank_nx_s = wr_bank_r;
        end
        if (rd_last_s) begin
            full_nx_s[rd_bank_r] = 1'b0;
            rd_bank_nx_s         = ~rd_bank_r;
        end else begin
            rd_bank_nx_s = rd_bank_r;
        end
    end

    assign cur_avail_s   = full_r[rd_bank_r] | (wr_last_s & (wr_bank_r == rd_bank_r));
    assign next_avail_s  = full_r[~rd_bank_r] | (wr_last_s & (wr_bank_r != rd_bank_r));
    assign in_ready_nx_s = ~full_nx_s[wr_bank_nx_s];
    assign same_bank_s   = (wr_bank_r == rd_bank_nx_s);
    assign bank_we_s     = {accept_s & wr_bank_r, accept_s & ~wr_bank_r};

    // Bank pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
        end else begin
            wr_bank_r <= wr_bank_nx_s;
            rd_bank_r <= rd_bank_nx_s;
        end
    end

    // Triple source: the bank the read side will be pointing at after this edge.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_sel_s[k] = bank_rd_s[rd_bank_nx_s][k];
        end
    end
`else
    // Single bank: full from the Nth write until the last triple leaves.
    always_comb begin
        if (wr_last_s) begin
            full_nx_s = 1'b1;
        end else if (rd_last_s) begin
            full_nx_s = 1'b0;
        end else begin
            full_nx_s = full_r;
        end
    end

    assign cur_avail_s   = full_r[0] | wr_last_s;
    assign next_avail_s  = 1'b0;
    assign in_ready_nx_s = ~full_nx_s[0];
    assign same_bank_s   = 1'b1;
    assign bank_we_s     = accept_s;

    // Triple source: the only bank.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_sel_s[k] = bank_rd_s[0][k];
        end
    end
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        r3_bank #(
            .N  (N),
            .AW (AW)
        ) u_bank (
            .clk    (clk),
            .we     (bank_we_s[b]),
            .waddr  (wr_cnt_r),
            .wdata  (in_cplx_s),
            .raddr0 (ra_s[0]),
            .raddr1 (ra_s[1]),
            .raddr2 (ra_s[2]),
            .rdata0 (bank_rd_s[b][0]),
            .rdata1 (bank_rd_s[b][1]),
            .rdata2 (bank_rd_s[b][2])
        );
    end

    assign ra_s[0] = AW'(ld_idx_s);
    assign ra_s[1] = AW'(ld_idx_s) + OFS1;
    assign ra_s[2] = AW'(ld_idx_s) + OFS2;

    // Read-side FSM: load triple 0 when a full bank is available, step on each transfer.
    always_comb begin
        state_nx_s    = state_r;
        rd_cnt_nx_s   = rd_cnt_r;
        out_last_nx_s = out_last_r;
        ld_idx_s      = rd_cnt_r;
        load_s        = 1'b0;
        case (state_r)
            DRAIN: begin
                if (rd_last_s) begin
                    rd_cnt_nx_s   = ZERO_T;
                    ld_idx_s      = ZERO_T;
                    load_s        = next_avail_s;
                    out_last_nx_s = next_avail_s & (ZERO_T == RD_LAST);
                    state_nx_s    = next_avail_s ? DRAIN : FILL;
                end else if (xfer_s) begin
                    rd_cnt_nx_s   = rd_cnt_r + ONE_T;
                    ld_idx_s      = rd_cnt_r + ONE_T;
                    load_s        = 1'b1;
                    out_last_nx_s = ((rd_cnt_r + ONE_T) == RD_LAST);
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            FILL: begin
                if (cur_avail_s) begin
                    rd_cnt_nx_s   = ZERO_T;
                    ld_idx_s      = ZERO_T;
                    load_s        = 1'b1;
                    out_last_nx_s = (ZERO_T == RD_LAST);
                    state_nx_s    = DRAIN;
                end else begin
                    out_last_nx_s = 1'b0;
                end
            end
            default: begin
                state_nx_s    = FILL;
                out_last_nx_s = 1'b0;
            end
        endcase
    end

    // The sample written on this edge can be part of the triple loaded on it (x2 when N = 3).
    logic [2:0] bypass_s;
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bypass_s[k] = accept_s & same_bank_s & (wr_cnt_r == ra_s[k]);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= FILL;
            wr_cnt_r   <= ZERO_A;
            rd_cnt_r   <= ZERO_T;
            full_r     <= {NB{1'b0}};
            in_ready_r <= 1'b1;
            out_last_r <= 1'b0;
            x0_r       <= CPLX_ZERO;
            x1_r       <= CPLX_ZERO;
            x2_r       <= CPLX_ZERO;
        end else begin
            state_r    <= state_nx_s;
            wr_cnt_r   <= wr_cnt_nx_s;
            rd_cnt_r   <= rd_cnt_nx_s;
            full_r     <= full_nx_s;
            in_ready_r <= in_ready_nx_s;
            out_last_r <= out_last_nx_s;
            if (load_s) begin
                x0_r <= bypass_s[0] ? in_cplx_s : rd_sel_s[0];
                x1_r <= bypass_s[1] ? in_cplx_s : rd_sel_s[1];
                x2_r <= bypass_s[2] ? in_cplx_s : rd_sel_s[2];
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = draining_s;
    assign out_idx   = rd_cnt_r;
    assign out_last  = out_last_r;
    assign x0_re     = x0_r.re;
    assign x0_im     = x0_r.im;
    assign x1_re     = x1_r.re;
    assign x1_im     = x1_r.im;
    assign x2_re     = x2_r.re;
    assign x2_im     = x2_r.im;

endmodule

// File: tb/tb_r3_stride_gather.sv
// Directed self-checking bench for r3_stride_gather (N = 9); inputs change and outputs are sampled on the falling edge.
module tb_r3_stride_gather;

    localparam int N = 9;
`ifdef R3_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    localparam logic [31:0] B0 = 32'h3F80_0000;
    localparam logic [31:0] B1 = 32'h4000_0000;
    localparam logic [31:0] B2 = 32'hDEAD_0000;
    localparam logic [31:0] B3 = 32'h4100_0000;
    localparam logic [31:0] B4 = 32'h4200_0000;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_re, in_im, x0_re, x0_im, x1_re, x1_im, x2_re, x2_im;
    logic [1:0]  out_idx;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    r3_stride_gather #(.N(N), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0_re     (x0_re),
        .x0_im     (x0_im),
        .x1_re     (x1_re),
        .x1_im     (x1_im),
        .x2_re     (x2_re),
        .x2_im     (x2_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    function automatic logic [31:0] smp(input logic [31:0] base, input int k);
        return base + 32'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one input cycle and advance to the next falling edge.
    task automatic put(input logic v, input logic [31:0] re);
        in_valid = v;
        in_re    = re;
        in_im    = ~re;
        @(negedge clk);
    endtask

    // Feed samples from..N-1 of a frame, with `gap` idle garbage cycles between samples.
    task automatic send(input logic [31:0] base, input int from, input int gap);
        for (int k = from; k < N; k++) begin
            chk("ov_during_fill", 64'(out_valid), 64'd0);
            put(1'b1, smp(base, k));
            if (k < N - 1) begin
                for (int g = 0; g < gap; g++) put(1'b0, 32'hBAD0_0000 ^ 32'(g * 7 + k));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_triple(input logic [31:0] base, input int t);
        logic [31:0] e0, e1, e2;
        e0 = smp(base, t);
        e1 = smp(base, t + 3);
        e2 = smp(base, t + 6);
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("x0", {x0_re, x0_im}, {e0, ~e0});
        chk("x1", {x1_re, x1_im}, {e1, ~e1});
        chk("x2", {x2_re, x2_im}, {e2, ~e2});
        chk("out_idx", 64'(out_idx), 64'(t));
        chk("out_last", 64'(out_last), (t == 2) ? 64'd1 : 64'd0);
    endtask

    // Check a full drain with out_ready held high, then the return to fill.
    task automatic drain(input logic [31:0] base);
        for (int t = 0; t < 3; t++) begin
            chk_triple(base, t);
            chk("in_ready_drain", 64'(in_ready), 64'(PP));
            @(negedge clk);
        end
        chk("ov_after_drain", 64'(out_valid), 64'd0);
        chk("ir_after_drain", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = 32'h0;
        in_im     = 32'h0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_x", {x0_re, x1_im, 32'h0} | {32'h0, x2_re | x0_im | x1_re | x2_im}, 64'd0);
        rst_n = 1'b1;

        // Basic drain
        out_ready = 1'b1;
        send(B0, 0, 0);
        drain(B0);

        // Backpressure on triple 1
        send(B1, 0, 0);
        chk_triple(B1, 0);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_triple(B1, 1);
            chk("in_ready_bp", 64'(in_ready), 64'(PP));
            @(negedge clk);
        end
        chk_triple(B1, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk_triple(B1, 2);
        @(negedge clk);
        chk("ov_after_bp", 64'(out_valid), 64'd0);

        // Gapped input
        send(B0, 0, 2);
        drain(B0);

        // Reset mid-frame
        for (int k = 0; k < 4; k++) put(1'b1, smp(B2, k));
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("ov_after_rst", 64'(out_valid), 64'd0);
        chk("ir_after_rst", 64'(in_ready), 64'd1);
        send(B0, 0, 0);
        drain(B0);

`ifndef R3_PINGPONG_EN
        // in_valid held high through the drain: next frame's s0 waits for in_ready
        send(B3, 0, 0);
        in_valid = 1'b1;
        in_re    = smp(B4, 0);
        in_im    = ~smp(B4, 0);
        drain(B3);
        send(B4, 0, 0);
        drain(B4);
`else
        // Three frames streamed back to back
        begin
            int tcnt;
            tcnt = 0;
            for (int c = 0; c < 40; c++) begin
                if (out_valid) begin
                    if (tcnt < 9) chk_triple(B3 + 32'((tcnt / 3) << 8), tcnt % 3);
                    tcnt++;
                end
                if (c < 27) begin
                    chk("pp_in_ready", 64'(in_ready), 64'd1);
                    put(1'b1, smp(B3 + 32'((c / 9) << 8), c % 9));
                end else begin
                    put(1'b0, 32'h0);
                end
            end
            chk("pp_triple_count", 64'(tcnt), 64'd9);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
